regfile_sb: RTL and testbench

//  Parametrised multi-port CPU register file for the pipelined core.
//  - Two synchronous write ports: A = ALU writeback, B = load writeback.
//  - NRD combinational read ports, with write-through bypass.
//  - PC register sourced externally.
//  - Per-register busy scoreboard that flags read-after-write hazards to the decode stage.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_read_port.sv | 71 +++++++
 rtl/regfile_sb.sv | 126 ++++++++++++
 tb/tb_regfile_sb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared defaults and types for the pipelined-core register file.
//   N_DEF      : address width (2**N architectural registers)
//   M_DEF      : data width
//   NRD_DEF    : number of combinational read ports (Rn, Rm, Rs)
//   PC_REG_DEF : architectural index of the PC
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int N_DEF      = 4;
  localparam int M_DEF      = 32;
  localparam int NRD_DEF    = 3;
  localparam int PC_REG_DEF = 15;

  typedef logic [N_DEF-1:0] reg_addr_t;
  typedef logic [M_DEF-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of the register file, with write-through
//   bypass from both writeback ports and scoreboard hazard detection.
// Ports
//   i_ra        read address
//   i_mem_word  stored word at i_ra (selected by the top level)
//   i_r15       PC+8 value from fetch, returned for the PC address
//   i_we_a/i_wa_a/i_wd_a  port A writeback (enable already qualified by reset)
//   i_we_b/i_wa_b/i_wd_b  port B writeback (enable already qualified by reset)
//   i_busy      scoreboard bitmap
//   o_rd        read data
//   o_hazard    the addressed register has a producer still in flight
// ---------------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int M      = M_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic [N-1:0]      i_ra,
  input  logic [M-1:0]      i_mem_word,
  input  logic [M-1:0]      i_r15,
  input  logic              i_we_a,
  input  logic [N-1:0]      i_wa_a,
  input  logic [M-1:0]      i_wd_a,
  input  logic              i_we_b,
  input  logic [N-1:0]      i_wa_b,
  input  logic [M-1:0]      i_wd_b,
  input  logic [2**N-1:0]   i_busy,
  output logic [M-1:0]      o_rd,
  output logic              o_hazard
);

  localparam logic [N-1:0] PC_ADDR = N'(PC_REG);

  logic w_is_pc;
  logic w_hit_a;
  logic w_hit_b;

  assign w_is_pc = (i_ra == PC_ADDR);
  assign w_hit_a = i_we_a & (i_wa_a == i_ra);
  assign w_hit_b = i_we_b & (i_wa_b == i_ra);

  // Read data select: PC first, then port A bypass, port B bypass, storage.
  always_comb begin
    o_rd = i_mem_word;
    if (w_is_pc) begin
      o_rd = i_r15;
    end else if (w_hit_a) begin
      o_rd = i_wd_a;
    end else if (w_hit_b) begin
      o_rd = i_wd_b;
    end else begin
      o_rd = i_mem_word;
    end
  end

  // Hazard: a writeback landing this cycle is forwarded by the bypass, so it
  // resolves the hazard immediately; the PC is never tracked.
  always_comb begin
    o_hazard = 1'b0;
    if (w_is_pc) begin
      o_hazard = 1'b0;
    end else begin
      o_hazard = i_busy[i_ra] & ~(w_hit_a | w_hit_b);
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Multi-port CPU register file with write-through bypass and a per-register
//   busy scoreboard for read-after-write hazard detection.
// Ports
//   clk, rst_n            clock (rising edge) / synchronous active-low reset
//   we_a, wa_a, wd_a      port A (ALU writeback)
//   we_b, wa_b, wd_b      port B (load writeback); port A wins on collision
//   ra / rd               NRD packed read addresses / read data
//   r15                   PC+8 from fetch, returned for reads of PC_REG
//   iss_valid, iss_dst    issuing instruction marks its destination busy
//   busy                  registered scoreboard bitmap
//   hazard                per read port: operand still pending
//   wr_conflict           both ports write the same address this cycle
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int M      = M_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_a,
  input  logic [N-1:0]       wa_a,
  input  logic [M-1:0]       wd_a,
  input  logic               we_b,
  input  logic [N-1:0]       wa_b,
  input  logic [M-1:0]       wd_b,
  input  logic [NRD*N-1:0]   ra,
  output logic [NRD*M-1:0]   rd,
  input  logic [M-1:0]       r15,
  input  logic               iss_valid,
  input  logic [N-1:0]       iss_dst,
  output logic [2**N-1:0]    busy,
  output logic [NRD-1:0]     hazard,
  output logic               wr_conflict
);

  localparam int NREG = 2**N;

  logic [M-1:0]    r_mem [NREG];
  logic [NREG-1:0] r_busy;

  // Write enables qualified by reset: writes, bypass and scoreboard clears
  // are all inert in a reset cycle.
  logic            w_we_a;
  logic            w_we_b;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  assign w_we_a      = we_a & rst_n;
  assign w_we_b      = we_b & rst_n;
  assign wr_conflict = we_a & we_b & (wa_a == wa_b);
  assign busy        = r_busy;

  // Per-register scoreboard set (issue) and clear (writeback) decode.
  always_comb begin
    w_set = {NREG{1'b0}};
    w_clr = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      if (i == PC_REG) begin
        w_set[i] = 1'b0;
      end else begin
        w_set[i] = iss_valid & (iss_dst == N'(i));
      end
      w_clr[i] = (w_we_a & (wa_a == N'(i))) | (w_we_b & (wa_b == N'(i)));
    end
  end

  // Register storage; the PC slot is held at zero so mem never holds the PC.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) begin
        r_mem[i] <= {M{1'b0}};
      end else if (i == PC_REG) begin
        r_mem[i] <= {M{1'b0}};
      end else if (w_we_a && (wa_a == N'(i))) begin
        r_mem[i] <= wd_a;
      end else if (w_we_b && (wa_b == N'(i))) begin
        r_mem[i] <= wd_b;
      end else begin
        r_mem[i] <= r_mem[i];
      end
    end
  end

  // Busy bitmap: a new issue outranks a same-cycle writeback of the old producer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_set | (r_busy & ~w_clr);
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [N-1:0] w_ra_k;
      assign w_ra_k = ra[k*N +: N];

      regfile_read_port #(
        .N      (N),
        .M      (M),
        .PC_REG (PC_REG)
      ) u_rp (
        .i_ra       (w_ra_k),
        .i_mem_word (r_mem[w_ra_k]),
        .i_r15      (r15),
        .i_we_a     (w_we_a),
        .i_wa_a     (wa_a),
        .i_wd_a     (wd_a),
        .i_we_b     (w_we_b),
        .i_wa_b     (wa_b),
        .i_wd_b     (wd_b),
        .i_busy     (r_busy),
        .o_rd       (rd[k*M +: M]),
        .o_hazard   (hazard[k])
      );
    end
  endgenerate

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Directed and random stimulus for regfile_sb. Each cycle the reference
//   model's expected outputs are pushed to a scoreboard queue when the
//   stimulus is applied and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int N    = N_DEF;
  localparam int M    = M_DEF;
  localparam int NRD  = NRD_DEF;
  localparam int PC   = PC_REG_DEF;
  localparam int NREG = 2**N;
  localparam logic [N-1:0] PC_A = N'(PC);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             we_a, we_b, iss_valid;
  logic [N-1:0]     wa_a, wa_b, iss_dst;
  logic [M-1:0]     wd_a, wd_b, r15;
  logic [NRD*N-1:0] ra;
  logic [NRD*M-1:0] rd;
  logic [NREG-1:0]  busy;
  logic [NRD-1:0]   hazard;
  logic             wr_conflict;

  regfile_sb #(.N(N), .M(M), .NRD(NRD), .PC_REG(PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .rd(rd), .r15(r15),
    .iss_valid(iss_valid), .iss_dst(iss_dst),
    .busy(busy), .hazard(hazard), .wr_conflict(wr_conflict)
  );

  // Stimulus staged by the directed steps, applied at the falling edge.
  logic             s_rst_n, s_we_a, s_we_b, s_iv;
  logic [N-1:0]     s_wa_a, s_wa_b, s_dst;
  logic [M-1:0]     s_wd_a, s_wd_b, s_r15;
  logic [NRD*N-1:0] s_ra;

  // Reference model state.
  logic [M-1:0]    m_mem [NREG];
  logic [NREG-1:0] m_busy;

  typedef struct {
    logic [NRD*M-1:0] rd;
    logic [NRD-1:0]   hz;
    logic [NREG-1:0]  bz;
    logic             wc;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [NRD*M-1:0] last_rd;
  logic [NRD-1:0]   last_hz;
  logic [NREG-1:0]  last_bz;
  logic             last_wc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [NRD*N-1:0] ras(input logic [N-1:0] a0, input logic [N-1:0] a1,
                                           input logic [N-1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic idle();
    s_rst_n = 1'b1; s_we_a = 1'b0; s_we_b = 1'b0; s_iv = 1'b0;
  endtask

  // One clock cycle: apply, predict+push, sample+pop+compare, then advance model.
  task automatic tick();
    exp_t e;
    logic [N-1:0] a;
    logic hit_a, hit_b, set, clr;
    logic [NREG-1:0] nb;
    @(negedge clk);
    rst_n = s_rst_n; we_a = s_we_a; wa_a = s_wa_a; wd_a = s_wd_a;
    we_b = s_we_b; wa_b = s_wa_b; wd_b = s_wd_b; ra = s_ra; r15 = s_r15;
    iss_valid = s_iv; iss_dst = s_dst;
    for (int k = 0; k < NRD; k++) begin
      a = s_ra[k*N +: N];
      hit_a = s_rst_n && s_we_a && (s_wa_a == a);
      hit_b = s_rst_n && s_we_b && (s_wa_b == a);
      if (a == PC_A)  e.rd[k*M +: M] = s_r15;
      else if (hit_a) e.rd[k*M +: M] = s_wd_a;
      else if (hit_b) e.rd[k*M +: M] = s_wd_b;
      else            e.rd[k*M +: M] = m_mem[a];
      e.hz[k] = (a != PC_A) && m_busy[a] && !(hit_a || hit_b);
    end
    e.bz = m_busy;
    e.wc = s_we_a && s_we_b && (s_wa_a == s_wa_b);
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      chk("rd", rd, e.rd);
      chk("hazard", hazard, e.hz);
      chk("busy", busy, e.bz);
      chk("wr_conflict", wr_conflict, e.wc);
    end
    last_rd = rd; last_hz = hazard; last_bz = busy; last_wc = wr_conflict;
    @(posedge clk);
    cyc++;
    if (!s_rst_n) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      for (int i = 0; i < NREG; i++) begin
        a   = N'(i);
        set = s_iv && (s_dst == a) && (i != PC);
        clr = (s_we_a && (s_wa_a == a)) || (s_we_b && (s_wa_b == a));
        nb[i] = set || (m_busy[i] && !clr);
      end
      if (s_we_b && (s_wa_b != PC_A)) m_mem[s_wa_b] = s_wd_b;
      if (s_we_a && (s_wa_a != PC_A)) m_mem[s_wa_a] = s_wd_a;
      m_busy = nb;
    end
  endtask

  initial begin
    // Power-up reset applied directly; the model starts from the reset state.
    rst_n = 1'b0; we_a = 1'b0; we_b = 1'b0; iss_valid = 1'b0;
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; iss_dst = '0;
    ra = '0; r15 = '0;
    s_wa_a = '0; s_wa_b = '0; s_wd_a = '0; s_wd_b = '0; s_dst = '0;
    s_ra = '0; s_r15 = 32'h0000_0008;
    idle();
    repeat (2) @(posedge clk);
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_busy = '0;

    // Reset state.
    idle(); s_ra = ras(4'd0, 4'd1, 4'd2); tick();
    chk("rst_rd", last_rd, 96'd0);
    chk("rst_busy", last_bz, 16'd0);

    // 1. Write R3, mark R6 busy, then reset clears both.
    idle(); s_we_a = 1'b1; s_wa_a = 4'd3; s_wd_a = 32'hDEAD_BEEF;
    s_iv = 1'b1; s_dst = 4'd6; s_ra = ras(4'd3, 4'd0, 4'd0); tick();
    chk("t1_bypass", last_rd[0 +: M], 32'hDEAD_BEEF);
    idle(); tick();
    chk("t1_stored", last_rd[0 +: M], 32'hDEAD_BEEF);
    chk("t1_busy6", last_bz[6], 1'b1);
    idle(); s_rst_n = 1'b0; s_we_a = 1'b1; s_wa_a = 4'd3; s_wd_a = 32'h77; tick();
    chk("t1_rst_nobypass", last_rd[0 +: M], 32'hDEAD_BEEF);
    idle(); tick();
    chk("t1_after_rst", last_rd[0 +: M], 32'd0);
    chk("t1_busy_clr", last_bz, 16'd0);

    // 2. Basic write / read on both ports.
    idle(); s_we_a = 1'b1; s_wa_a = 4'd2; s_wd_a = 32'h11;
    s_we_b = 1'b1; s_wa_b = 4'd7; s_wd_b = 32'h22; tick();
    idle(); s_ra = ras(4'd2, 4'd7, 4'd0); tick();
    chk("t2_rd0", last_rd[0 +: M], 32'h11);
    chk("t2_rd1", last_rd[M +: M], 32'h22);

    // 3. Bypass and same-address collision.
    idle(); s_we_a = 1'b1; s_wa_a = 4'd5; s_wd_a = 32'hA5; s_ra = ras(4'd5, 4'd2, 4'd7); tick();
    chk("t3_bypass", last_rd[0 +: M], 32'hA5);
    idle(); s_we_a = 1'b1; s_wa_a = 4'd5; s_wd_a = 32'h1;
    s_we_b = 1'b1; s_wa_b = 4'd5; s_wd_b = 32'h2; tick();
    chk("t3_conflict", last_wc, 1'b1);
    chk("t3_conf_byp", last_rd[0 +: M], 32'h1);
    idle(); tick();
    chk("t3_a_wins", last_rd[0 +: M], 32'h1);
    chk("t3_no_conflict", last_wc, 1'b0);

    // 4. PC handling.
    s_r15 = 32'h108;
    idle(); s_ra = ras(4'd5, 4'd2, 4'd15); tick();
    chk("t4_pc_read", last_rd[2*M +: M], 32'h108);
    idle(); s_we_a = 1'b1; s_wa_a = 4'd15; s_wd_a = 32'h55; s_iv = 1'b1; s_dst = 4'd15; tick();
    chk("t4_pc_nobypass", last_rd[2*M +: M], 32'h108);
    idle(); tick();
    chk("t4_pc_after", last_rd[2*M +: M], 32'h108);
    chk("t4_busy15", last_bz[15], 1'b0);

    // 5. Scoreboard.
    idle(); s_iv = 1'b1; s_dst = 4'd4; s_ra = ras(4'd4, 4'd15, 4'd0); tick();
    chk("t5_hz_before", last_hz[0], 1'b0);
    idle(); tick();
    chk("t5_busy4", last_bz[4], 1'b1);
    chk("t5_hazard0", last_hz[0], 1'b1);
    chk("t5_hazard_pc", last_hz[1], 1'b0);
    idle(); s_we_b = 1'b1; s_wa_b = 4'd4; s_wd_b = 32'h44; tick();
    chk("t5_wb_hazard", last_hz[0], 1'b0);
    chk("t5_wb_rd", last_rd[0 +: M], 32'h44);
    idle(); tick();
    chk("t5_busy4_clr", last_bz[4], 1'b0);
    idle(); s_iv = 1'b1; s_dst = 4'd4; tick();
    idle(); s_iv = 1'b1; s_dst = 4'd4; s_we_a = 1'b1; s_wa_a = 4'd4; s_wd_a = 32'h45; tick();
    idle(); tick();
    chk("t5_set_wins", last_bz[4], 1'b1);
    chk("t5_set_wins_hz", last_hz[0], 1'b1);
    idle(); s_we_a = 1'b1; s_wa_a = 4'd4; s_wd_a = 32'h46; tick();
    idle(); tick();
    chk("t5_final_clr", last_bz[4], 1'b0);

    // 6. Random traffic with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      s_rst_n = ($urandom_range(63) != 0);
      s_we_a  = $urandom_range(1); s_wa_a = N'($urandom); s_wd_a = $urandom;
      s_we_b  = $urandom_range(1); s_wa_b = N'($urandom); s_wd_b = $urandom;
      s_iv    = $urandom_range(1); s_dst  = N'($urandom);
      s_ra    = NRD*N'($urandom);
      s_r15   = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_sb
